// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - RTC bus master and field refresh scheduler
//
// Each refresh tick sweeps FIELD_COUNT RTC fields over a multiplexed
// address/data bus. After each read the field register gets a one-cycle load
// strobe. User write-backs are slotted in between sweep accesses.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   tick                           refresh request pulse
//   edit_mode                      suppresses sweeps; bank sources edit counters
//   write_req/field/data           write-back request, captured on acceptance
//   write_ready, write_ack         write slot free / write access completed
//   busy                           bus access in progress
//   ad_out, ad_oe, ad_in           multiplexed bus drive, drive enable, read value
//   ad_sel_n, cs_n, rd_n, wr_n     RTC phase select and strobes (active-low)
//   load_en, rtc_data              one-hot field load strobe, last sampled data
//   src_sel                        bank source select (edit_mode delayed 1 clk)
module rtc_bus_sequencer #(
   parameter int N           = 8,
   parameter int FIELD_COUNT = 6,
   parameter int BASE_ADDR   = 'h21,
   parameter int T_PHASE     = 4,
   localparam int FW = (FIELD_COUNT > 1) ? $clog2(FIELD_COUNT) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick,
   input  logic                   edit_mode,
   input  logic                   write_req,
   input  logic [FW-1:0]          write_field,
   input  logic [N-1:0]           write_data,
   output logic                   write_ready,
   output logic                   write_ack,
   output logic                   busy,
   output logic [N-1:0]           ad_out,
   output logic                   ad_oe,
   input  logic [N-1:0]           ad_in,
   output logic                   ad_sel_n,
   output logic                   cs_n,
   output logic                   rd_n,
   output logic                   wr_n,
   output logic [FIELD_COUNT-1:0] load_en,
   output logic [N-1:0]           rtc_data,
   output logic                   src_sel
);

   localparam int CW = $clog2(FIELD_COUNT + 1);
   localparam int PW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

   typedef enum logic [2:0] {IDLE, A_ASSERT, A_RELEASE, D_ASSERT, D_RELEASE} state_t;

   state_t        state;
   logic [PW-1:0] phase;
   logic          acc_write;
   logic [CW-1:0] acc_field;
   logic [N-1:0]  acc_data;

   // next_field is the next field to read; equal to FIELD_COUNT once the
   // last read of the sweep has been launched.
   logic          sweep_on;
   logic          sweep_pend;
   logic [CW-1:0] next_field;

   logic          slot_full;
   logic [FW-1:0] slot_field;
   logic [N-1:0]  slot_data;

   logic          phase_last;
   logic          boundary;
   logic          accept;
   logic          accept_ok;
   logic          sweep_on_c;
   logic          sweep_pend_c;
   logic [CW-1:0] next_field_c;
   logic          start_wr;
   logic          start_rd;
   logic [CW-1:0] start_field;
   logic [N-1:0]  start_data;

   assign phase_last = (phase == PW'(T_PHASE - 1));
   // New accesses are only launched from idle or on the final clk of an access.
   assign boundary   = (state == IDLE) || ((state == D_RELEASE) && phase_last);
   assign accept     = write_req && write_ready;
   assign accept_ok  = accept && (int'(write_field) < FIELD_COUNT);

   always_comb begin
      sweep_on_c   = sweep_on;
      sweep_pend_c = sweep_pend;
      next_field_c = next_field;
      start_wr     = 1'b0;
      start_rd     = 1'b0;
      start_field  = CW'(slot_field);
      start_data   = slot_data;

      if (tick && !edit_mode) begin
         if (sweep_on) begin
            sweep_pend_c = 1'b1;
         end else begin
            sweep_on_c   = 1'b1;
            next_field_c = '0;
         end
      end

      if (boundary) begin
         if (edit_mode) begin
            sweep_on_c   = 1'b0;
            sweep_pend_c = 1'b0;
         end
         if (sweep_on_c && (next_field_c == CW'(FIELD_COUNT))) begin
            if (sweep_pend_c) begin
               sweep_pend_c = 1'b0;
               next_field_c = '0;
            end else begin
               sweep_on_c = 1'b0;
            end
         end
         // A write (held or arriving this clk) always beats the next sweep read.
         if (slot_full) begin
            start_wr = 1'b1;
         end else if (accept_ok) begin
            start_wr    = 1'b1;
            start_field = CW'(write_field);
            start_data  = write_data;
         end else if (sweep_on_c) begin
            start_rd     = 1'b1;
            start_field  = next_field_c;
            next_field_c = next_field_c + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         phase       <= '0;
         acc_write   <= 1'b0;
         acc_field   <= '0;
         acc_data    <= '0;
         sweep_on    <= 1'b0;
         sweep_pend  <= 1'b0;
         next_field  <= '0;
         slot_full   <= 1'b0;
         slot_field  <= '0;
         slot_data   <= '0;
         write_ready <= 1'b1;
         write_ack   <= 1'b0;
         busy        <= 1'b0;
         ad_out      <= '0;
         ad_oe       <= 1'b0;
         ad_sel_n    <= 1'b1;
         cs_n        <= 1'b1;
         rd_n        <= 1'b1;
         wr_n        <= 1'b1;
         load_en     <= '0;
         rtc_data    <= '0;
         src_sel     <= 1'b0;
      end else begin
         src_sel    <= edit_mode;
         load_en    <= '0;
         sweep_on   <= sweep_on_c;
         sweep_pend <= sweep_pend_c;
         next_field <= next_field_c;

         // Slot frees on the clk after the ack pulse.
         if (write_ack) write_ready <= 1'b1;
         write_ack <= 1'b0;
         if (accept) begin
            write_ready <= 1'b0;
            if (!accept_ok) begin
               write_ack <= 1'b1;
            end else if (!start_wr) begin
               slot_full  <= 1'b1;
               slot_field <= write_field;
               slot_data  <= write_data;
            end
         end
         if (start_wr) slot_full <= 1'b0;

         if (start_wr || start_rd) begin
            state     <= A_ASSERT;
            phase     <= '0;
            busy      <= 1'b1;
            acc_write <= start_wr;
            acc_field <= start_field;
            acc_data  <= start_data;
            ad_out    <= N'(BASE_ADDR + int'(start_field));
            ad_oe     <= 1'b1;
            ad_sel_n  <= 1'b0;
            cs_n      <= 1'b0;
            wr_n      <= 1'b0;
            rd_n      <= 1'b1;
         end else if (state != IDLE) begin
            if (!phase_last) begin
               phase <= phase + 1'b1;
               if ((state == D_RELEASE) && acc_write && (phase == PW'(T_PHASE - 2)))
                  write_ack <= 1'b1;
            end else begin
               phase <= '0;
               case (state)
                  A_ASSERT: begin
                     state <= A_RELEASE;
                     wr_n  <= 1'b1;
                  end
                  A_RELEASE: begin
                     state    <= D_ASSERT;
                     ad_sel_n <= 1'b1;
                     if (acc_write) begin
                        ad_out <= acc_data;
                        wr_n   <= 1'b0;
                     end else begin
                        ad_oe <= 1'b0;
                        rd_n  <= 1'b0;
                     end
                  end
                  D_ASSERT: begin
                     state <= D_RELEASE;
                     cs_n  <= 1'b1;
                     rd_n  <= 1'b1;
                     wr_n  <= 1'b1;
                     ad_oe <= 1'b0;
                     if (!acc_write) begin
                        rtc_data <= ad_in;
                        load_en  <= FIELD_COUNT'(1) << acc_field;
                     end
                  end
                  default: begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - self-checking bench for rtc_bus_sequencer
module tb_rtc_bus_sequencer;

   localparam int FC = 6;
   localparam int TP = 4;
   localparam int BA = 'h21;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic        edit_mode = 1'b0;
   logic        write_req = 1'b0;
   logic [2:0]  write_field = '0;
   logic [7:0]  write_data = '0;
   logic        write_ready, write_ack, busy, ad_oe, ad_sel_n, cs_n, rd_n, wr_n, src_sel;
   logic [7:0]  ad_out, ad_in, rtc_data;
   logic [5:0]  load_en;

   int checks = 0;
   int errors = 0;

   rtc_bus_sequencer dut (
      .clk(clk), .reset(reset), .tick(tick), .edit_mode(edit_mode),
      .write_req(write_req), .write_field(write_field), .write_data(write_data),
      .write_ready(write_ready), .write_ack(write_ack), .busy(busy),
      .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .ad_sel_n(ad_sel_n),
      .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .load_en(load_en),
      .rtc_data(rtc_data), .src_sel(src_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h", name, act, exp);
      end
   endtask

   // RTC device: latches address in the address phase, stores on data-phase writes.
   logic [7:0] rtc_mem [0:255];
   logic [7:0] dev_addr;
   always @(posedge clk) begin
      if (reset) begin
         dev_addr <= '0;
         for (int i = 0; i < 256; i++) rtc_mem[i] <= 8'h00;
         for (int i = 0; i < FC; i++) rtc_mem[BA + i] <= 8'(8'h10 + i);
      end else begin
         if (!cs_n && !ad_sel_n) dev_addr <= ad_out;
         if (!cs_n && ad_sel_n && !wr_n) rtc_mem[dev_addr] <= ad_out;
      end
   end
   assign ad_in = rtc_mem[dev_addr];

   // Transaction-level model: one access is 4*TP clks counted by m_k.
   bit   m_busy, m_wr, m_sweep, m_pend, m_slot, m_ready, m_ack, m_src;
   int   m_k, m_field, m_next, m_load, m_sfield;
   logic [7:0] m_data, m_rtc, m_sdata;
   bit   acc, acc_ok, bnd;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 0; m_k = 0; m_wr = 0; m_sweep = 0; m_pend = 0; m_next = 0;
         m_slot = 0; m_ready = 1; m_ack = 0; m_load = -1; m_rtc = 0; m_src = 0;
      end else begin
         acc    = write_req && m_ready;
         acc_ok = acc && (int'(write_field) < FC);
         m_src  = edit_mode;
         if (m_ack) m_ready = 1;
         m_ack  = 0;
         m_load = -1;
         if (tick && !edit_mode) begin
            if (m_sweep) m_pend = 1;
            else begin m_sweep = 1; m_next = 0; end
         end
         bnd = !m_busy || (m_k == 4*TP - 1);
         if (m_busy) begin
            if (!m_wr && m_k == 3*TP - 1) begin m_rtc = ad_in; m_load = m_field; end
            if (m_wr && m_k == 4*TP - 2) m_ack = 1;
            if (m_k == 4*TP - 1) m_busy = 0; else m_k++;
         end
         if (bnd) begin
            if (edit_mode) begin m_sweep = 0; m_pend = 0; end
            if (m_sweep && m_next == FC) begin
               if (m_pend) begin m_pend = 0; m_next = 0; end else m_sweep = 0;
            end
            if (m_slot) begin
               m_busy = 1; m_k = 0; m_wr = 1; m_field = m_sfield; m_data = m_sdata; m_slot = 0;
            end else if (acc_ok) begin
               m_busy = 1; m_k = 0; m_wr = 1; m_field = int'(write_field); m_data = write_data;
               acc_ok = 0;
            end else if (m_sweep) begin
               m_busy = 1; m_k = 0; m_wr = 0; m_field = m_next; m_next++;
            end
         end
         if (acc) begin
            m_ready = 0;
            if (int'(write_field) >= FC) m_ack = 1;
            else if (acc_ok) begin m_slot = 1; m_sfield = int'(write_field); m_sdata = write_data; end
         end
      end
   end

   // Event logs for the literal expectations.
   int         cyc = 0;
   int         n_acc, n_ld, n_ack, t_fall;
   int         acc_t [64];
   int         acc_addr [64];
   int         acc_wr [64];
   int         acc_wd [64];
   int         ld_field [64];
   int         ld_data [64];
   logic       prev_cs = 1'b1;
   logic       prev_busy = 1'b0;
   int         p;
   bit         e_cs, e_sel, e_wr, e_rd, e_oe;
   logic [5:0] e_load;

   task automatic clear_logs();
      n_acc = 0; n_ld = 0; n_ack = 0; t_fall = 0;
      for (int i = 0; i < 64; i++) begin
         acc_t[i] = 0; acc_addr[i] = 0; acc_wr[i] = 0; acc_wd[i] = 0;
         ld_field[i] = 0; ld_data[i] = 0;
      end
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      if (!cs_n && prev_cs && n_acc < 64) begin
         acc_t[n_acc] = cyc; acc_addr[n_acc] = int'(ad_out); n_acc++;
      end
      if (!cs_n && ad_sel_n && !wr_n && n_acc > 0) begin
         acc_wr[n_acc-1] = 1; acc_wd[n_acc-1] = int'(ad_out);
      end
      for (int i = 0; i < FC; i++)
         if (load_en[i] && n_ld < 64) begin
            ld_field[n_ld] = i; ld_data[n_ld] = int'(rtc_data); n_ld++;
         end
      if (write_ack) n_ack++;
      if (prev_busy && !busy) t_fall = cyc;
      prev_cs = cs_n;
      prev_busy = busy;

      p      = m_k / TP;
      e_cs   = !(m_busy && p <= 2);
      e_sel  = !(m_busy && p <= 1);
      e_wr   = !(m_busy && (p == 0 || (p == 2 && m_wr)));
      e_rd   = !(m_busy && p == 2 && !m_wr);
      e_oe   = m_busy && (p <= 1 || (p == 2 && m_wr));
      e_load = (m_load >= 0) ? (6'b000001 << m_load) : 6'b000000;
      chk("cs_n", cs_n, e_cs);
      chk("ad_sel_n", ad_sel_n, e_sel);
      chk("wr_n", wr_n, e_wr);
      chk("rd_n", rd_n, e_rd);
      chk("ad_oe", ad_oe, e_oe);
      if (e_oe) chk("ad_out", ad_out, (p <= 1) ? (BA + m_field) : int'(m_data));
      chk("busy", busy, m_busy);
      chk("load_en", load_en, e_load);
      chk("rtc_data", rtc_data, m_rtc);
      chk("write_ack", write_ack, m_ack);
      chk("write_ready", write_ready, m_ready);
      chk("src_sel", src_sel, m_src);
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin @(negedge clk); n++; end
      chk("idle_timeout", busy, 0);
      repeat (20) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_logs();
      repeat (3) @(negedge clk);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_ad_oe", ad_oe, 0);
      chk("rst_ad_out", ad_out, 0);
      chk("rst_load_en", load_en, 0);
      chk("rst_write_ready", write_ready, 1);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // 1: single sweep
      clear_logs();
      tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      wait_idle(300);
      chk("t1_n_acc", n_acc, 6);
      for (int i = 0; i < FC; i++) begin
         chk("t1_addr", acc_addr[i], BA + i);
         chk("t1_spacing", acc_t[i] - acc_t[0], 16 * i);
         chk("t1_ld_field", ld_field[i], i);
         chk("t1_ld_data", ld_data[i], 'h10 + i);
      end
      chk("t1_busy_len", t_fall - acc_t[0], 96);

      // 2: pending sweep, extra ticks dropped
      clear_logs();
      tick = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         tick = (c == 40 || c == 41 || c == 50);
      end
      wait_idle(300);
      chk("t2_n_acc", n_acc, 12);
      chk("t2_no_gap", acc_t[6] - acc_t[5], 16);
      chk("t2_addr6", acc_addr[6], BA);
      chk("t2_addr11", acc_addr[11], BA + 5);

      // 3: write inserted mid-sweep
      clear_logs();
      tick = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         tick = 1'b0;
         write_req = (c == 20);
         if (c == 20) begin write_field = 3'd2; write_data = 8'h59; end
      end
      wait_idle(300);
      chk("t3_n_acc", n_acc, 7);
      chk("t3_addr1", acc_addr[1], BA + 1);
      chk("t3_wr_addr", acc_addr[2], 'h23);
      chk("t3_wr_flag", acc_wr[2], 1);
      chk("t3_wr_data", acc_wd[2], 'h59);
      chk("t3_resume_addr", acc_addr[3], 'h23);
      chk("t3_n_ack", n_ack, 1);
      chk("t3_n_ld", n_ld, 6);
      chk("t3_ld2_data", ld_data[2], 'h59);

      // 4: edit mode
      clear_logs();
      edit_mode = 1'b1;
      @(negedge clk);
      chk("t4_src_sel", src_sel, 1);
      tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      repeat (5) @(negedge clk);
      tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      repeat (30) @(negedge clk);
      chk("t4_ignored", n_acc, 0);
      edit_mode = 1'b0;
      repeat (3) @(negedge clk);
      tick = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         tick = 1'b0;
         if (c == 50) edit_mode = 1'b1;
      end
      wait_idle(300);
      chk("t4_n_acc", n_acc, 4);
      chk("t4_n_ld", n_ld, 4);
      chk("t4_last_ld", ld_field[3], 3);
      edit_mode = 1'b0;
      repeat (3) @(negedge clk);

      // 5: reset during read data phase
      clear_logs();
      tick = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         tick = 1'b0;
      end
      chk("t5_pre_rd_n", rd_n, 0);
      reset = 1'b1;
      #1;
      chk("t5_cs_n", cs_n, 1);
      chk("t5_rd_n", rd_n, 1);
      chk("t5_ad_oe", ad_oe, 0);
      chk("t5_write_ready", write_ready, 1);
      @(negedge clk);
      @(negedge clk) reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("t5_no_load", n_ld, 0);

      // 6: tick and write together; write while not ready is ignored
      clear_logs();
      tick = 1'b1; write_req = 1'b1; write_field = 3'd4; write_data = 8'h47;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         tick = 1'b0;
         write_req = (c == 5);
         if (c == 5) begin
            write_field = 3'd5; write_data = 8'h33;
            chk("t6_not_ready", write_ready, 0);
         end
      end
      write_req = 1'b0;
      wait_idle(300);
      chk("t6_n_acc", n_acc, 7);
      chk("t6_first_addr", acc_addr[0], 'h25);
      chk("t6_first_wr", acc_wr[0], 1);
      chk("t6_first_data", acc_wd[0], 'h47);
      chk("t6_then_f0", acc_addr[1], BA);
      chk("t6_n_ack", n_ack, 1);
      chk("t6_ld4", ld_data[4], 'h47);
      chk("t6_ld5", ld_data[5], 'h15);

      // 7: out-of-range write field: dropped, still acked
      clear_logs();
      write_req = 1'b1; write_field = 3'd7; write_data = 8'hAA;
      @(negedge clk) write_req = 1'b0;
      repeat (20) @(negedge clk);
      chk("t7_no_access", n_acc, 0);
      chk("t7_ack", n_ack, 1);
      chk("t7_ready", write_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
